// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter
// Two-master round-robin arbiter and sequencer for the single LSU port.
// Master 0 is the core data path, master 1 a debug/DMA engine. One command
// is accepted at a time, registered, presented to the LSU for one ISSUE cycle
// plus RD_LAT WAIT cycles, and its load data is returned to the owner as a
// one-cycle response.
//
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_mN_req/wren/addr/      master N command (held until o_mN_gnt)
//     wdata/mask
//   o_mN_gnt                 combinational accept, only in IDLE
//   o_mN_rvalid/o_mN_rdata   one-cycle response; rdata persists until the
//                            next response to the same master
//   o_lsu_addr/wdata/mask    command to LSU, driven in ISSUE and WAIT
//   o_lsu_wren               store strobe, ISSUE cycle only
//   i_lsu_rdata              LSU load data, sampled RD_LAT cycles after ISSUE
//   o_busy                   high whenever a transaction is in flight
module lsu_port_arbiter #(
  parameter int RD_LAT = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_mask,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_mask,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic [3:0]  o_lsu_mask,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_rdata,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] WAIT_INIT = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;    // owner of the most recent grant
  logic        owner_q, owner_d;
  logic        wren_q, wren_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        gnt0, gnt1, sample;
  logic [31:0] resp_data;

  always_comb begin
    // Grants are suppressed while reset is held so every output reads 0.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && !i_reset) begin
      if (i_m0_req && i_m1_req) begin
        gnt0 = last_q;   // last=1 means master 1 went last, so master 0 wins
        gnt1 = !last_q;
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    sample     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          wren_d  = gnt1 ? i_m1_wren  : i_m0_wren;
          addr_d  = gnt1 ? i_m1_addr  : i_m0_addr;
          wdata_d = gnt1 ? i_m1_wdata : i_m0_wdata;
          mask_d  = gnt1 ? i_m1_mask  : i_m0_mask;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (RD_LAT == 0) begin
          sample  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          sample  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The response data lands in the owner's register at the sampling edge,
    // so it is already visible during RESP and persists afterwards.
    resp_data = wren_q ? 32'd0 : i_lsu_rdata;
    if (sample) begin
      if (owner_q) m1_rdata_d = resp_data;
      else         m0_rdata_d = resp_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      mask_q     <= 4'd0;
      cnt_q      <= 4'd0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // LSU outputs decode from the state register so an asynchronous reset
  // clears them immediately.
  logic drive;
  assign drive = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign o_lsu_addr  = drive ? addr_q  : 32'd0;
  assign o_lsu_wdata = drive ? wdata_q : 32'd0;
  assign o_lsu_mask  = drive ? mask_q  : 4'd0;
  assign o_lsu_wren  = (state_q == S_ISSUE) && wren_q;
  assign o_busy      = (state_q != S_IDLE);

  assign o_m0_gnt    = gnt0;
  assign o_m1_gnt    = gnt1;
  assign o_m0_rvalid = (state_q == S_RESP) && !owner_q;
  assign o_m1_rvalid = (state_q == S_RESP) && owner_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter. Three instances cover RD_LAT = 0, 2, 3.
module tb_lsu_port_arbiter;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        m0_req    [3];
  logic        m0_wren   [3];
  logic [31:0] m0_addr   [3];
  logic [31:0] m0_wdata  [3];
  logic [3:0]  m0_mask   [3];
  logic        m0_gnt    [3];
  logic        m0_rvalid [3];
  logic [31:0] m0_rdata  [3];
  logic        m1_req    [3];
  logic        m1_wren   [3];
  logic [31:0] m1_addr   [3];
  logic [31:0] m1_wdata  [3];
  logic [3:0]  m1_mask   [3];
  logic        m1_gnt    [3];
  logic        m1_rvalid [3];
  logic [31:0] m1_rdata  [3];
  logic [31:0] lsu_addr  [3];
  logic [31:0] lsu_wdata [3];
  logic [3:0]  lsu_mask  [3];
  logic        lsu_wren  [3];
  logic [31:0] lsu_rdata [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    lsu_port_arbiter #(.RD_LAT(LAT)) u_dut (
      .i_clk       (clk),
      .i_reset     (rst[g]),
      .i_m0_req    (m0_req[g]),
      .i_m0_wren   (m0_wren[g]),
      .i_m0_addr   (m0_addr[g]),
      .i_m0_wdata  (m0_wdata[g]),
      .i_m0_mask   (m0_mask[g]),
      .o_m0_gnt    (m0_gnt[g]),
      .o_m0_rvalid (m0_rvalid[g]),
      .o_m0_rdata  (m0_rdata[g]),
      .i_m1_req    (m1_req[g]),
      .i_m1_wren   (m1_wren[g]),
      .i_m1_addr   (m1_addr[g]),
      .i_m1_wdata  (m1_wdata[g]),
      .i_m1_mask   (m1_mask[g]),
      .o_m1_gnt    (m1_gnt[g]),
      .o_m1_rvalid (m1_rvalid[g]),
      .o_m1_rdata  (m1_rdata[g]),
      .o_lsu_addr  (lsu_addr[g]),
      .o_lsu_wdata (lsu_wdata[g]),
      .o_lsu_mask  (lsu_mask[g]),
      .o_lsu_wren  (lsu_wren[g]),
      .i_lsu_rdata (lsu_rdata[g]),
      .o_busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      m0_req[i] = 1'b0; m0_wren[i] = 1'b0; m0_addr[i] = '0; m0_wdata[i] = '0; m0_mask[i] = '0;
      m1_req[i] = 1'b0; m1_wren[i] = 1'b0; m1_addr[i] = '0; m1_wdata[i] = '0; m1_mask[i] = '0;
      lsu_rdata[i] = '0;
    end

    // Reset state, with a request pending to show gnt is held off.
    cyc();
    m0_req[0] = 1'b1;
    #1;
    chk("rst_gnt0", m0_gnt[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_addr", lsu_addr[0], 0);
    chk("rst_wren", lsu_wren[0], 0);
    chk("rst_rv0", m0_rvalid[0], 0);
    chk("rst_rd0", m0_rdata[0], 0);
    m0_req[0] = 1'b0;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    cyc();

    // RD_LAT=0 single load from master 0.
    m0_req[0] = 1'b1; m0_addr[0] = 32'h10; m0_wren[0] = 1'b0; m0_mask[0] = 4'hf;
    #1;
    chk("t1_gnt0", m0_gnt[0], 1);
    chk("t1_gnt1", m1_gnt[0], 0);
    cyc();
    m0_req[0] = 1'b0; lsu_rdata[0] = 32'hDEADBEEF;
    #1;
    chk("t1_addr", lsu_addr[0], 32'h10);
    chk("t1_wren", lsu_wren[0], 0);
    chk("t1_busy", busy[0], 1);
    cyc();
    chk("t1_rv0", m0_rvalid[0], 1);
    chk("t1_rd0", m0_rdata[0], 32'hDEADBEEF);
    chk("t1_rv1", m1_rvalid[0], 0);
    chk("t1_resp_addr", lsu_addr[0], 0);
    cyc();
    chk("t1_rv0_end", m0_rvalid[0], 0);
    chk("t1_rd0_hold", m0_rdata[0], 32'hDEADBEEF);
    chk("t1_idle", busy[0], 0);

    // Continuous contention from reset: grants alternate every 3 cycles.
    #2 rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    m0_req[0] = 1'b1; m0_addr[0] = 32'h100;
    m1_req[0] = 1'b1; m1_addr[0] = 32'h200; m1_wren[0] = 1'b0;
    lsu_rdata[0] = 32'h12345678;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("t2_gnt0_c%0d", c), m0_gnt[0], (c % 6 == 0) ? 1 : 0);
      chk($sformatf("t2_gnt1_c%0d", c), m1_gnt[0], (c % 6 == 3) ? 1 : 0);
      chk($sformatf("t2_rv0_c%0d", c), m0_rvalid[0], (c % 6 == 2) ? 1 : 0);
      chk($sformatf("t2_rv1_c%0d", c), m1_rvalid[0], (c % 6 == 5) ? 1 : 0);
      if (c % 6 == 1) chk($sformatf("t2_addr_c%0d", c), lsu_addr[0], 32'h100);
      if (c % 6 == 4) chk($sformatf("t2_addr_c%0d", c), lsu_addr[0], 32'h200);
      if (c % 6 == 2) chk($sformatf("t2_rd0_c%0d", c), m0_rdata[0], 32'h12345678);
      if (c == 11) begin
        m0_req[0] = 1'b0;
        m1_req[0] = 1'b0;
      end
      @(posedge clk);
    end
    #1;

    // Master 1 store: single wren pulse, response data forced to 0.
    m1_req[0] = 1'b1; m1_wren[0] = 1'b1; m1_addr[0] = 32'h1000_0000;
    m1_wdata[0] = 32'h0000_00FF; m1_mask[0] = 4'b0001;
    #1;
    chk("t3_gnt1", m1_gnt[0], 1);
    chk("t3_gnt0", m0_gnt[0], 0);
    chk("t3_wren_idle", lsu_wren[0], 0);
    cyc();
    m1_req[0] = 1'b0; lsu_rdata[0] = 32'hCAFEF00D;
    #1;
    chk("t3_wren", lsu_wren[0], 1);
    chk("t3_addr", lsu_addr[0], 32'h1000_0000);
    chk("t3_wdata", lsu_wdata[0], 32'h0000_00FF);
    chk("t3_mask", lsu_mask[0], 4'b0001);
    cyc();
    chk("t3_wren_resp", lsu_wren[0], 0);
    chk("t3_rv1", m1_rvalid[0], 1);
    chk("t3_rd1", m1_rdata[0], 0);
    chk("t3_rd0_hold", m0_rdata[0], 32'h12345678);
    chk("t3_mask_resp", lsu_mask[0], 0);
    cyc();
    chk("t3_rv1_end", m1_rvalid[0], 0);
    chk("t3_wren_end", lsu_wren[0], 0);
    m1_wren[0] = 1'b0;

    // Master 0 pulses req while master 1 owns the port: never granted.
    m1_req[0] = 1'b1; m1_addr[0] = 32'h300;
    #1;
    chk("t6_gnt1", m1_gnt[0], 1);
    cyc();
    m1_req[0] = 1'b0; m0_req[0] = 1'b1;
    #1;
    chk("t6_gnt0_issue", m0_gnt[0], 0);
    cyc();
    m0_req[0] = 1'b0;
    chk("t6_gnt0_resp", m0_gnt[0], 0);
    chk("t6_rv1", m1_rvalid[0], 1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("t6_gnt0_idle%0d", c), m0_gnt[0], 0);
      chk($sformatf("t6_busy_idle%0d", c), busy[0], 0);
    end

    // RD_LAT=2 load: data sampled at the end of the second WAIT cycle.
    m0_req[1] = 1'b1; m0_addr[1] = 32'h40; m0_wren[1] = 1'b0; m0_mask[1] = 4'hf;
    #1;
    chk("t4_gnt0", m0_gnt[1], 1);
    cyc();
    m0_req[1] = 1'b0; lsu_rdata[1] = 32'h1;
    #1;
    chk("t4_addr_issue", lsu_addr[1], 32'h40);
    cyc();
    lsu_rdata[1] = 32'h2;
    #1;
    chk("t4_addr_wait1", lsu_addr[1], 32'h40);
    chk("t4_wren_wait1", lsu_wren[1], 0);
    cyc();
    lsu_rdata[1] = 32'h3;
    #1;
    chk("t4_addr_wait2", lsu_addr[1], 32'h40);
    chk("t4_rv0_wait2", m0_rvalid[1], 0);
    cyc();
    chk("t4_rv0", m0_rvalid[1], 1);
    chk("t4_rd0", m0_rdata[1], 32'h3);
    chk("t4_addr_resp", lsu_addr[1], 0);

    // RD_LAT=3: reset in the second WAIT cycle aborts; m0 wins afterwards.
    m0_req[2] = 1'b1; m0_addr[2] = 32'h80; m0_wren[2] = 1'b0;
    #1;
    chk("t5_gnt0_first", m0_gnt[2], 1);
    cyc();
    m0_req[2] = 1'b0;
    m1_req[2] = 1'b1; m1_addr[2] = 32'h200;
    cyc();
    cyc();
    chk("t5_busy_wait2", busy[2], 1);
    chk("t5_addr_wait2", lsu_addr[2], 32'h80);
    #2 rst[2] = 1'b1;
    #1;
    chk("t5_busy_rst", busy[2], 0);
    chk("t5_addr_rst", lsu_addr[2], 0);
    chk("t5_rv0_rst", m0_rvalid[2], 0);
    chk("t5_gnt1_rst", m1_gnt[2], 0);
    m0_req[2] = 1'b1; m0_addr[2] = 32'h100;
    cyc();
    chk("t5_gnt0_rst", m0_gnt[2], 0);
    chk("t5_rv0_rst2", m0_rvalid[2], 0);
    rst[2] = 1'b0;
    #1;
    chk("t5_gnt0_tie", m0_gnt[2], 1);
    chk("t5_gnt1_tie", m1_gnt[2], 0);
    cyc();
    chk("t5_addr_new", lsu_addr[2], 32'h100);
    m0_req[2] = 1'b0; m1_req[2] = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
